reg_file_sb: RTL and testbench

//   Register file at the consuming end of the destination-register select path: receives the
//   5-bit write index chosen upstream (rt/rd), commits write-back data on the clock edge,
//   and serves two read ports to decode. Includes a busy scoreboard: issue marks a destination

---
 rtl/reg_file_sb_pkg.sv | 7 +
 rtl/reg_file_sb_scoreboard.sv | 29 ++
 rtl/reg_file_sb.sv | 66 ++++++
 tb/tb_reg_file_sb.sv | 127 ++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared sizing defaults and register-index constants for reg_file_sb
package reg_file_sb_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int REG_COUNT = 2 ** DEF_ADDR_WIDTH;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// reg_scoreboard: per-register busy bits, set on issue and cleared on write-back, set wins
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [ADDR_WIDTH-1:0] addr2,
  output logic                  busy1,
  output logic                  busy2
);
  localparam int COUNT = 2 ** ADDR_WIDTH;
  logic [COUNT-1:0] busy;
  // Busy update for every non-zero index; entry 0 is never set so it stays 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else
      for (int i = 1; i < COUNT; i++)
        if (set_en && set_addr == ADDR_WIDTH'(i)) busy[i] <= 1'b1;
        else if (clr_en && clr_addr == ADDR_WIDTH'(i)) busy[i] <= 1'b0;
  assign busy1 = busy[addr1];
  assign busy2 = busy[addr2];
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read/1-write register file with busy scoreboard; REG_BYPASS_EN enables write-to-read forwarding
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic                  busy1,
  output logic                  busy2
);
  localparam int COUNT = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);
  logic [DATA_WIDTH-1:0] regs [COUNT];
  logic [DATA_WIDTH-1:0] stored1, stored2;
  logic sb_busy1, sb_busy2;
  logic wr_en;
  assign wr_en = reg_write && write_addr != ZERO;
  // Write-back commit; register 0 is excluded by wr_en and so holds its reset zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < COUNT; i++) regs[i] <= '0;
    else if (wr_en) regs[write_addr] <= write_data;
  assign stored1 = read_addr1 == ZERO ? '0 : regs[read_addr1];
  assign stored2 = read_addr2 == ZERO ? '0 : regs[read_addr2];
  reg_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (issue_valid),
    .set_addr(issue_addr),
    .clr_en  (reg_write),
    .clr_addr(write_addr),
    .addr1   (read_addr1),
    .addr2   (read_addr2),
    .busy1   (sb_busy1),
    .busy2   (sb_busy2)
  );
`ifdef REG_BYPASS_EN
  logic fwd1, fwd2, set1, set2;
  // Forward same-cycle write-back data and its pending busy clear unless a new issue re-marks the index
  always_comb begin
    fwd1 = wr_en && read_addr1 == write_addr;
    fwd2 = wr_en && read_addr2 == write_addr;
    set1 = issue_valid && issue_addr == read_addr1;
    set2 = issue_valid && issue_addr == read_addr2;
    read_data1 = fwd1 ? write_data : stored1;
    read_data2 = fwd2 ? write_data : stored2;
    busy1 = sb_busy1 && !(fwd1 && !set1);
    busy2 = sb_busy2 && !(fwd2 && !set2);
  end
`else
  assign read_data1 = stored1;
  assign read_data2 = stored2;
  assign busy1 = sb_busy1;
  assign busy2 = sb_busy2;
`endif
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb
module tb_reg_file_sb;
  logic clk = 0, rst_n = 0;
  logic reg_write = 0, issue_valid = 0;
  logic [4:0] write_addr = 0, issue_addr = 0, read_addr1 = 0, read_addr2 = 0;
  logic [31:0] write_data = 0, read_data1, read_data2;
  logic busy1, busy2;
  int checks = 0, errors = 0;
  logic [31:0] exp;

  reg_file_sb dut (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .write_addr(write_addr),
    .write_data(write_data), .issue_valid(issue_valid), .issue_addr(issue_addr),
    .read_addr1(read_addr1), .read_addr2(read_addr2), .read_data1(read_data1),
    .read_data2(read_data2), .busy1(busy1), .busy2(busy2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    reg_write = 0;
    issue_valid = 0;
  endtask

  initial begin
    repeat (2) tick();
    check("reset_rd1", read_data1, 0);
    check("reset_busy1", {31'b0, busy1}, 0);
    rst_n = 1;
    // write/read register 5
    reg_write = 1; write_addr = 5; write_data = 32'hDEADBEEF; read_addr1 = 5;
    #1;
`ifdef REG_BYPASS_EN
    exp = 32'hDEADBEEF;
`else
    exp = 32'h0;
`endif
    check("wr5_same_cycle", read_data1, exp);
    tick(); idle();
    #1 check("wr5_next_cycle", read_data1, 32'hDEADBEEF);
    // dual port
    reg_write = 1; write_addr = 3; write_data = 32'h11;
    tick();
    write_addr = 4; write_data = 32'h22;
    tick(); idle();
    read_addr1 = 4; read_addr2 = 3;
    #1 check("dual_rd1", read_data1, 32'h22);
    check("dual_rd2", read_data2, 32'h11);
    read_addr1 = 3;
    #1 check("same_rd1", read_data1, 32'h11);
    check("same_rd2", read_data2, 32'h11);
    // register zero
    reg_write = 1; write_addr = 0; write_data = 32'hFFFFFFFF; issue_valid = 1; issue_addr = 0;
    tick(); idle();
    read_addr1 = 0; read_addr2 = 0;
    #1 check("zero_rd1", read_data1, 0);
    check("zero_rd2", read_data2, 0);
    check("zero_busy", {30'b0, busy1, busy2}, 0);
    // scoreboard issue 8 then write-back 8 three cycles later
    issue_valid = 1; issue_addr = 8; read_addr1 = 8;
    #1 check("sb8_same_cycle", {31'b0, busy1}, 0);
    tick(); idle();
    check("sb8_t1", {31'b0, busy1}, 1);
    tick();
    check("sb8_t2", {31'b0, busy1}, 1);
    tick();
    reg_write = 1; write_addr = 8; write_data = 32'h88;
    #1;
`ifdef REG_BYPASS_EN
    exp = 0;
`else
    exp = 1;
`endif
    check("sb8_t3", {31'b0, busy1}, exp);
    tick(); idle();
    check("sb8_t4", {31'b0, busy1}, 0);
    check("sb8_data", read_data1, 32'h88);
    // collision on 9: set wins
    issue_valid = 1; issue_addr = 9; read_addr2 = 9;
    tick();
    check("sb9_busy", {31'b0, busy2}, 1);
    reg_write = 1; write_addr = 9; write_data = 32'h99;
    #1 check("sb9_coll_same", {31'b0, busy2}, 1);
    tick(); idle();
    check("sb9_coll_next", {31'b0, busy2}, 1);
    check("sb9_data", read_data2, 32'h99);
    reg_write = 1; write_addr = 9; write_data = 32'h9A;
    tick(); idle();
    check("sb9_cleared", {31'b0, busy2}, 0);
    check("sb9_data2", read_data2, 32'h9A);
    // clear of a non-busy index, set of an already busy index
    reg_write = 1; write_addr = 10; write_data = 32'hA0; read_addr1 = 10;
    tick(); idle();
    check("sb10_nonbusy", {31'b0, busy1}, 0);
    issue_valid = 1; issue_addr = 10;
    tick();
    tick(); idle();
    check("sb10_reset_busy", {31'b0, busy1}, 1);
    // async reset mid-cycle, with a write held across the edge during reset
    read_addr2 = 5;
    #2 rst_n = 0;
    #1 check("rst_rd1", read_data1, 0);
    check("rst_rd2", read_data2, 0);
    check("rst_busy", {30'b0, busy1, busy2}, 0);
    reg_write = 1; write_addr = 7; write_data = 32'h77;
    tick(); idle();
    rst_n = 1;
    read_addr1 = 7;
    #1 check("rst_write_lost", read_data1, 0);
    check("rst_rd5", read_data2, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
